// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule definitions: S-box, xtime, FSM states and sizing constants.
package aes_pkg;

  localparam int          NR_DEF    = 10;
  localparam int          NB_WORDS  = 4 * (NR_DEF + 1);
  localparam logic [7:0]  RCON_INIT = 8'h01;

  typedef enum logic [1:0] {IDLE, EXPAND, READY} ks_state_e;

  // Row r holds S-box entries 16r .. 16r+15, index 0 leftmost
  localparam logic [0:255][7:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_subword.sv
// SubWord: four parallel S-box lookups on a 32-bit word, purely combinational.
module aes_subword
  import aes_pkg::*;
(
  input  logic [31:0] word,
  output logic [31:0] sub
);

  for (genvar b = 0; b < 4; b++) begin : g_lane
    assign sub[8*b +: 8] = sbox(word[8*b +: 8]);
  end

endmodule

// File: rtl/key_sched_ctrl.sv
// Iterative AES-128 key expansion (one word/clock) with a registered round-key read port.
// Optional KEY_SCHED_ZEROIZE_EN adds a zeroize input that wipes the key store.
module key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int NK = 4,
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_load,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         key_ready,
  input  logic         rk_req,
  input  logic [3:0]   rk_round,
  output logic         rk_valid,
  output logic [127:0] rk_data,
  output logic         rk_err
`ifdef KEY_SCHED_ZEROIZE_EN
  ,
  input  logic         zeroize
`endif
);

  localparam int NW = 4 * (NR + 1);

  ks_state_e          state, state_nxt;
  logic [5:0]         i;
  logic [7:0]         rcon;
  logic [NW-1:0][31:0] w;
  logic               clr, start, last;
  logic [31:0]        prev, rot_sub, temp, nxt_word;
  logic [5:0]         base;
  logic               rd_ok;

`ifdef KEY_SCHED_ZEROIZE_EN
  assign clr = zeroize;
`else
  assign clr = 1'b0;
`endif

  assign start     = key_load & ~clr;
  assign last      = (i == 6'(NW - 1));
  assign busy      = (state == EXPAND);
  assign key_ready = (state == READY);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = EXPAND;
      EXPAND:  if (start) state_nxt = EXPAND;
               else if (last) state_nxt = READY;
      READY:   if (start) state_nxt = EXPAND;
      default: state_nxt = IDLE;
    endcase
    if (clr) state_nxt = IDLE;
  end

  // Single shared SubWord path fed from the previous word
  assign prev = w[i - 6'd1];

  aes_subword u_subword (
    .word ({prev[23:0], prev[31:24]}),
    .sub  (rot_sub)
  );

  assign temp     = (i[1:0] == 2'b00) ? (rot_sub ^ {rcon, 24'h0}) : prev;
  assign nxt_word = w[i - 6'd4] ^ temp;

  always_ff @(posedge clk) begin
    if (rst) begin
      i    <= 6'(NK);
      rcon <= RCON_INIT;
    end else if (start) begin
      i    <= 6'(NK);
      rcon <= RCON_INIT;
    end else if (busy && !clr) begin
      i <= i + 6'd1;
      if (i[1:0] == 2'b00) rcon <= xtime(rcon);
    end
  end

  always_ff @(posedge clk) begin
`ifdef KEY_SCHED_ZEROIZE_EN
    if (rst || zeroize) w <= '0;
    else
`endif
    if (start) begin
      for (int k = 0; k < NK; k++) w[k] <= key_in[127 - 32*k -: 32];
    end else if (busy) begin
      w[i] <= nxt_word;
    end
  end

  // A same-cycle key_load or zeroize invalidates the store, so the read is refused
  assign base  = {rk_round, 2'b00};
  assign rd_ok = key_ready && !key_load && !clr && (rk_round <= 4'(NR));

  always_ff @(posedge clk) begin
    if (rst) begin
      rk_valid <= 1'b0;
      rk_err   <= 1'b0;
      rk_data  <= '0;
    end else begin
      rk_valid <= rk_req;
      rk_err   <= rk_req & ~rd_ok;
      rk_data  <= (rk_req && rd_ok) ?
                  {w[base], w[base + 6'd1], w[base + 6'd2], w[base + 6'd3]} : '0;
    end
  end

endmodule

// File: tb/tb_key_sched_ctrl.sv
// Self-checking bench for key_sched_ctrl: FIPS-197 and zero-key vectors, rejects, restart, reset, zeroize.
module tb_key_sched_ctrl;

  logic         clk = 1'b0;
  logic         rst, key_load, rk_req;
  logic [127:0] key_in;
  logic [3:0]   rk_round;
  logic         busy, key_ready, rk_valid, rk_err;
  logic [127:0] rk_data;
`ifdef KEY_SCHED_ZEROIZE_EN
  logic         zeroize;
`endif

  key_sched_ctrl dut (
    .clk(clk), .rst(rst), .key_load(key_load), .key_in(key_in),
    .busy(busy), .key_ready(key_ready), .rk_req(rk_req), .rk_round(rk_round),
    .rk_valid(rk_valid), .rk_data(rk_data), .rk_err(rk_err)
`ifdef KEY_SCHED_ZEROIZE_EN
    , .zeroize(zeroize)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
  localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  typedef struct {
    logic         err;
    logic [127:0] data;
    string        tag;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cnt;

  // Scoreboard: every response strobe pops the oldest expected read
  always @(negedge clk) begin
    if (rk_valid === 1'b1) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_rk_valid got err=%0b data=%h", rk_err, rk_data);
      end else begin
        e = sb.pop_front();
        if ({rk_err, rk_data} !== {e.err, e.data}) begin
          n_bad++;
          $display("FAIL %s got err=%0b data=%h exp err=%0b data=%h",
                   e.tag, rk_err, rk_data, e.err, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic pulse_load(input logic [127:0] k);
    key_in = k; key_load = 1'b1;
    @(negedge clk);
    key_load = 1'b0;
  endtask

  task automatic wait_busy(output int c);
    c = 0;
    while (busy === 1'b1 && c < 200) begin
      c++;
      @(negedge clk);
    end
  endtask

  // Issue one read, let the scoreboard see the response, then confirm it was a single strobe
  task automatic rd(input logic [3:0] r, input logic err, input logic [127:0] data, input string tag);
    rk_req = 1'b1; rk_round = r;
    sb.push_back('{err, data, tag});
    @(negedge clk);
    rk_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (rk_valid !== 1'b0 || sb.size() != 0) begin
      n_bad++;
      $display("FAIL %s_strobe got valid=%0b pending=%0d exp valid=0 pending=0", tag, rk_valid, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; key_load = 1'b0; key_in = '0; rk_req = 1'b0; rk_round = '0;
`ifdef KEY_SCHED_ZEROIZE_EN
    zeroize = 1'b0;
`endif
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, key_ready, rk_valid, rk_err} !== 4'b0000 || rk_data !== '0) begin
      n_bad++;
      $display("FAIL reset_state got busy=%0b rdy=%0b vld=%0b err=%0b data=%h exp all zero",
               busy, key_ready, rk_valid, rk_err, rk_data);
    end
    rst = 1'b0;
    @(negedge clk);
    rd(4'd0, 1'b1, '0, "read_before_load");
  endtask

  task automatic test_fips;
    pulse_load(FIPS_KEY);
    wait_busy(cnt);
    n_cmp++;
    if (cnt != 40 || key_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL fips_busy_cycles got busy=%0d rdy=%0b exp busy=40 rdy=1", cnt, key_ready);
    end
    rd(4'd0,  1'b0, FIPS_RK[0],  "fips_round0");
    rd(4'd1,  1'b0, FIPS_RK[1],  "fips_round1");
    rd(4'd10, 1'b0, FIPS_RK[10], "fips_round10");
  endtask

  task automatic test_back_to_back;
    logic [3:0] seq [10] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd11, 4'd7, 4'd8, 4'd9, 4'd15};
    for (int n = 0; n < 10; n++) begin
      rk_req = 1'b1; rk_round = seq[n];
      if (seq[n] > 4'd10) sb.push_back('{1'b1, 128'h0, "b2b_reject"});
      else                sb.push_back('{1'b0, FIPS_RK[seq[n]], "b2b_round"});
      @(negedge clk);
    end
    rk_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (rk_valid !== 1'b0 || sb.size() != 0) begin
      n_bad++;
      $display("FAIL b2b_drain got valid=%0b pending=%0d exp valid=0 pending=0", rk_valid, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_zero_key;
    pulse_load('0);
    wait_busy(cnt);
    n_cmp++;
    if (cnt != 40 || key_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL zero_busy_cycles got busy=%0d rdy=%0b exp busy=40 rdy=1", cnt, key_ready);
    end
    rd(4'd0,  1'b0, '0,        "zero_round0");
    rd(4'd1,  1'b0, ZERO_RK1,  "zero_round1");
    rd(4'd10, 1'b0, ZERO_RK10, "zero_round10");
  endtask

  task automatic test_reject;
    pulse_load(FIPS_KEY);
    repeat (4) @(negedge clk);
    rd(4'd1, 1'b1, '0, "read_while_busy");
    wait_busy(cnt);
    n_cmp++;
    if (cnt != 34 || key_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL busy_after_reject got busy=%0d rdy=%0b exp busy=34 rdy=1", cnt, key_ready);
    end
    rd(4'd11, 1'b1, '0, "round11_reject");
    rd(4'd15, 1'b1, '0, "round15_reject");
    // key_load and rk_req in the same READY cycle
    key_in = FIPS_KEY; key_load = 1'b1; rk_req = 1'b1; rk_round = 4'd1;
    sb.push_back('{1'b1, 128'h0, "load_vs_read"});
    @(negedge clk);
    key_load = 1'b0; rk_req = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || key_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL load_wins_state got busy=%0b rdy=%0b exp busy=1 rdy=0", busy, key_ready);
    end
    wait_busy(cnt);
    n_cmp++;
    if (cnt != 40 || sb.size() != 0) begin
      n_bad++;
      $display("FAIL load_wins_busy got busy=%0d pending=%0d exp busy=40 pending=0", cnt, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_restart;
    pulse_load('0);
    repeat (19) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || key_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL restart_mid got busy=%0b rdy=%0b exp busy=1 rdy=0", busy, key_ready);
    end
    pulse_load(FIPS_KEY);
    wait_busy(cnt);
    n_cmp++;
    if (cnt != 40 || key_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL restart_busy got busy=%0d rdy=%0b exp busy=40 rdy=1", cnt, key_ready);
    end
    rd(4'd10, 1'b0, FIPS_RK[10], "restart_round10");
    rd(4'd5,  1'b0, FIPS_RK[5],  "restart_round5");
  endtask

  task automatic test_rst_mid;
    pulse_load(FIPS_KEY);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || key_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid got busy=%0b rdy=%0b exp busy=0 rdy=0", busy, key_ready);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || key_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid_idle got busy=%0b rdy=%0b exp busy=0 rdy=0", busy, key_ready);
    end
    rd(4'd1, 1'b1, '0, "read_after_rst");
  endtask

`ifdef KEY_SCHED_ZEROIZE_EN
  task automatic test_zeroize;
    pulse_load(FIPS_KEY);
    wait_busy(cnt);
    zeroize = 1'b1;
    @(negedge clk);
    zeroize = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || key_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL zeroize_state got busy=%0b rdy=%0b exp busy=0 rdy=0", busy, key_ready);
    end
    rd(4'd1, 1'b1, '0, "read_after_zeroize");
    zeroize = 1'b1; key_load = 1'b1; key_in = FIPS_KEY;
    @(negedge clk);
    zeroize = 1'b0; key_load = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || key_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL zeroize_beats_load got busy=%0b rdy=%0b exp busy=0 rdy=0", busy, key_ready);
    end
    pulse_load(FIPS_KEY);
    wait_busy(cnt);
    rd(4'd1, 1'b0, FIPS_RK[1], "reload_after_zeroize");
  endtask
`endif

  initial begin
    test_reset();
    test_fips();
    test_back_to_back();
    test_zero_key();
    test_reject();
    test_restart();
    test_rst_mid();
`ifdef KEY_SCHED_ZEROIZE_EN
    test_zeroize();
`endif
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/key_sched_ctrl.md
Name: key_sched_ctrl

Overview:
- Sequential AES-128 key-schedule controller. It generates the 44-word expanded key iteratively, one 32-bit word per clock, through a single shared 4-byte SubWord path.
- Stores all 11 round keys in an internal register file and serves them to the cipher round sequencer over a request/valid read port.
- Replaces the fully unrolled combinational expansion in the area-optimised build; sits between key input registers and the round datapath.

Parameters:
NK, 4, key length in 32-bit words (only 4 supported)
NR, 10, number of rounds; register file holds NR+1 round keys

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
key_load  input  1  one-cycle pulse; latch key_in and start expansion
key_in  input  128  cipher key; [127:96] = w0 (first key byte in MSBs)
busy  output  1  high while expansion in progress
key_ready  output  1  high when all round keys valid
rk_req  input  1  round-key read request, single-cycle
rk_round  input  4  round index 0..NR
rk_valid  output  1  read response strobe, one cycle
rk_data  output  128  round key; [127:96] = w[4*round]
rk_err  output  1  pulses with rk_valid on a rejected read

Behaviour:
- Reset: state IDLE, busy=0, key_ready=0, rk_valid=0, rk_err=0, rk_data=0, word counter i=4, rcon=8'h01. Register file contents are don't-care; they are zeroed only with the optional feature.
- FSM states:
  - IDLE: key_load -> LOAD action, go to EXPAND.
  - EXPAND: one word per cycle; after word 43 is written -> READY.
  - READY: key_load -> restart in EXPAND.
- LOAD action, at the edge sampling key_load: w0..w3 <= key_in; i <= 4; rcon <= 8'h01; busy <= 1; key_ready <= 0.
- EXPAND, each cycle:
  - temp = w[i-1].
  - If i%4==0: temp = SubWord(RotWord(temp)) ^ {rcon,24'h0}, and rcon <= xtime(rcon) (0x80 -> 0x1b).
  - w[i] <= w[i-4] ^ temp; i <= i+1.
- Latency: key_load sampled at edge E0; words 4..43 written at edges E1..E40. At E40, busy drops and key_ready rises together. busy is high for exactly 40 cycles.
- key_load during EXPAND aborts the current expansion and restarts from the new key with the same timing. No partial result is ever flagged ready.
- Read port, registered, 1-cycle latency:
  - rk_req at edge Ek gives rk_valid=1 at Ek+1.
  - Accepted read (key_ready=1 and rk_round<=NR): rk_data = {w[4r],w[4r+1],w[4r+2],w[4r+3]}, rk_err=0.
  - Rejected read (not ready, or rk_round>NR): rk_valid=1, rk_err=1, rk_data=0.
  - rk_valid/rk_err are single-cycle strobes. Back-to-back requests are served every cycle.
- Simultaneous key_load and rk_req in READY: key_load wins; the read is rejected (rk_err=1).
- rst asserted mid-expansion returns to IDLE next edge with key_ready=0.

Optional Feature:
- Macro KEY_SCHED_ZEROIZE_EN.
- When defined: a 1-bit input port zeroize is added.
  - A pulse (or rst) clears all 44 words to 0, sets key_ready=0, and goes to IDLE within one edge.
  - zeroize has priority over key_load.
- When undefined: no port, no clear logic; the register file is not reset.

Decomposition:
- Shared package aes_pkg holds:
  - SBOX byte-substitution function
  - xtime function
  - state enum (IDLE/EXPAND/READY)
  - NB_WORDS = 4*(NR+1) constant
  - RCON_INIT = 8'h01
- One sub-module, aes_subword: 4 parallel S-box lookups on a 32-bit word, combinational, instanced once.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, load then wait:
  - busy high exactly 40 cycles.
  - read round 1 -> a0fafe1788542cb123a339392a6c7605.
  - read round 10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
- All-zero key:
  - round 0 -> 0.
  - round 1 -> 62636363626363636263636362636363.
  - round 10 -> b4ef5bcb3e92e21123e951cf6f8f188e.
- rk_req at cycle 5 of expansion, and rk_round=11 while ready -> rk_valid=1, rk_err=1, rk_data=0 on the following cycle.
- Load zero key, re-pulse key_load with the FIPS key at expansion cycle 20 -> busy stays high another 40 cycles; round 10 = d014f9a8...0ca6.
- rst at expansion cycle 10 -> IDLE, key_ready=0, busy=0 next cycle; subsequent reads return rk_err=1.
- With KEY_SCHED_ZEROIZE_EN: zeroize after expansion -> key_ready=0 and reads give rk_err. A zeroize+key_load pulse in the same cycle -> zeroize wins; busy stays 0.
